// File: rtl/cpu_controller.sv
`default_nettype none
// ============================================================================
// Module      : cpu_controller
// Description : Instruction register, decoder and control FSM for the simple
//               RISC machine. Latches a 16-bit instruction, decodes it and
//               sequences every datapath control input one instruction at a
//               time under a start/wait handshake.
// Ports       : clk, reset           - clock, synchronous active-high reset
//               in[15:0], load       - instruction word and IR capture strobe
//               s / w                - start request / idle indication
//               readnum, writenum    - register-file read/write indices
//               write                - register-file write enable
//               loada..loads         - datapath register load enables
//               asel, bsel           - operand mux selects
//               shift, ALUop         - shifter and ALU controls
//               vsel[3:0]            - one-hot writeback select
//               sximm5, sximm8       - sign-extended immediates
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] in,
    input  logic        load,
    input  logic        s,
    output logic        w,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        write,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic [3:0]  vsel,
    output logic [15:0] sximm5,
    output logic [15:0] sximm8
);

    typedef enum logic [2:0] {
        S_WAIT      = 3'd0,
        S_DECODE    = 3'd1,
        S_WRITE_IMM = 3'd2,
        S_GET_A     = 3'd3,
        S_GET_B     = 3'd4,
        S_ALU       = 3'd5,
        S_WRITE_REG = 3'd6
    } state_t;

    localparam logic [3:0] c_VSEL_SXIMM8 = 4'b0100;
    localparam logic [3:0] c_VSEL_C      = 4'b0001;

    state_t      r_state;
    state_t      w_next_state;
    logic [15:0] r_ir;

    // IR field extraction
    logic [2:0] w_opcode;
    logic [1:0] w_op;
    logic [2:0] w_rn;
    logic [2:0] w_rd;
    logic [2:0] w_rm;
    logic       w_is_mov_imm;
    logic       w_is_mov_reg;
    logic       w_is_alu;
    logic       w_is_cmp;

    assign w_opcode     = r_ir[15:13];
    assign w_op         = r_ir[12:11];
    assign w_rn         = r_ir[10:8];
    assign w_rd         = r_ir[7:5];
    assign w_rm         = r_ir[2:0];
    assign w_is_mov_imm = (w_opcode == 3'b110) && (w_op == 2'b10);
    assign w_is_mov_reg = (w_opcode == 3'b110) && (w_op == 2'b00);
    assign w_is_alu     = (w_opcode == 3'b101);
    assign w_is_cmp     = w_is_alu && (w_op == 2'b01);

    // Always-on outputs taken straight from the IR
    assign sximm8 = {{8{r_ir[7]}}, r_ir[7:0]};
    assign sximm5 = {{11{r_ir[4]}}, r_ir[4:0]};
    assign shift  = r_ir[4:3];
    assign ALUop  = w_is_alu ? w_op : 2'b00;
    assign bsel   = 1'b0;

    // State register and IR. The IR only accepts a new word while idle so an
    // instruction in flight can never be altered; a simultaneous load and
    // start lets DECODE see the freshly loaded word.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_WAIT;
            r_ir    <= 16'h0000;
        end else begin
            r_state <= w_next_state;
            if (load && (r_state == S_WAIT)) begin
                r_ir <= in;
            end
        end
    end

    // Next-state and Moore outputs
    always_comb begin
        w_next_state = r_state;
        w            = 1'b0;
        readnum      = 3'd0;
        writenum     = 3'd0;
        write        = 1'b0;
        loada        = 1'b0;
        loadb        = 1'b0;
        loadc        = 1'b0;
        loads        = 1'b0;
        asel         = 1'b0;
        vsel         = 4'b0000;

        case (r_state)
            S_WAIT: begin
                w = 1'b1;
                if (s) begin
                    w_next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                if (w_is_mov_imm)      w_next_state = S_WRITE_IMM;
                else if (w_is_mov_reg) w_next_state = S_GET_B;
                else if (w_is_alu)     w_next_state = S_GET_A;
                else                   w_next_state = S_WAIT;
            end
            S_WRITE_IMM: begin
                writenum     = w_rn;
                vsel         = c_VSEL_SXIMM8;
                write        = 1'b1;
                w_next_state = S_WAIT;
            end
            S_GET_A: begin
                readnum      = w_rn;
                loada        = 1'b1;
                w_next_state = S_GET_B;
            end
            S_GET_B: begin
                readnum      = w_rm;
                loadb        = 1'b1;
                w_next_state = S_ALU;
            end
            S_ALU: begin
                loadc = 1'b1;
                // MOV reg passes B through, so the A operand is forced to 0
                asel  = w_is_mov_reg;
                loads = w_is_cmp;
                // CMP only updates status; nothing to write back
                w_next_state = w_is_cmp ? S_WAIT : S_WRITE_REG;
            end
            S_WRITE_REG: begin
                writenum     = w_rd;
                vsel         = c_VSEL_C;
                write        = 1'b1;
                w_next_state = S_WAIT;
            end
            default: begin
                w_next_state = S_WAIT;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_controller
// Description : Self-checking bench for cpu_controller. Expected per-cycle
//               control vectors are queued when an instruction is launched
//               and popped/compared as the controller steps through it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_controller;

    logic        clk;
    logic        reset;
    logic [15:0] in;
    logic        load;
    logic        s;
    logic        w;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic        bsel;
    logic [1:0]  shift;
    logic [1:0]  ALUop;
    logic [3:0]  vsel;
    logic [15:0] sximm5;
    logic [15:0] sximm8;

    int n_tests = 0;
    int n_fail  = 0;

    logic [17:0] exp_q[$];

    cpu_controller dut (
        .clk      (clk),
        .reset    (reset),
        .in       (in),
        .load     (load),
        .s        (s),
        .w        (w),
        .readnum  (readnum),
        .writenum (writenum),
        .write    (write),
        .loada    (loada),
        .loadb    (loadb),
        .loadc    (loadc),
        .loads    (loads),
        .asel     (asel),
        .bsel     (bsel),
        .shift    (shift),
        .ALUop    (ALUop),
        .vsel     (vsel),
        .sximm5   (sximm5),
        .sximm8   (sximm8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed control vector: {w, readnum, writenum, write, loada, loadb,
    // loadc, loads, asel, bsel, vsel}
    logic [17:0] obs;
    assign obs = {w, readnum, writenum, write, loada, loadb, loadc, loads,
                  asel, bsel, vsel};

    function automatic logic [17:0] mk(input logic wv, input logic [2:0] rn,
                                       input logic [2:0] wn, input logic wr,
                                       input logic la, input logic lb,
                                       input logic lc, input logic ls,
                                       input logic as, input logic [3:0] vs);
        return {wv, rn, wn, wr, la, lb, lc, ls, as, 1'b0, vs};
    endfunction

    logic [17:0] e_idle;
    logic [17:0] e_dec;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_tests++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    // Load a word, then start it (or both on the same edge when together=1).
    task automatic launch(input logic [15:0] word, input bit together);
        if (!together) begin
            in = word; load = 1'b1;
            tick();
            load = 1'b0;
            check("idle_before_start", {14'd0, obs}, {14'd0, e_idle});
            s = 1'b1;
            tick();
            s = 1'b0;
        end else begin
            in = word; load = 1'b1; s = 1'b1;
            tick();
            load = 1'b0; s = 1'b0;
        end
    endtask

    // Pop and compare one expected vector per cycle. Optionally disturb with
    // a load or a reset during a given step. Bounded by the queue length.
    task automatic drain(input string name, input int disturb_at, input int reset_at);
        int k;
        logic [17:0] e;
        k = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check($sformatf("%s step%0d", name, k), {14'd0, obs}, {14'd0, e});
            if (exp_q.size() == 0) break;
            if (k == disturb_at) begin in = 16'hD007; load = 1'b1; end
            if (k == reset_at) reset = 1'b1;
            tick();
            load = 1'b0;
            reset = 1'b0;
            k++;
        end
    endtask

    initial begin
        e_idle = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000);
        e_dec  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000);

        // Reset held with s=1: must stay idle with no enables
        reset = 1'b1; s = 1'b1; load = 1'b0; in = 16'h0000;
        tick();
        tick();
        check("reset_ctrl", {14'd0, obs}, {14'd0, e_idle});
        check("reset_sximm8", {16'd0, sximm8}, 32'h0000_0000);
        check("reset_sximm5", {16'd0, sximm5}, 32'h0000_0000);
        reset = 1'b0; s = 1'b0;
        tick();
        check("post_reset_idle", {14'd0, obs}, {14'd0, e_idle});

        // MOV R0,#7
        launch(16'hD007, 1'b0);
        check("mov7_sximm8", {16'd0, sximm8}, 32'h0000_0007);
        exp_q.push_back(e_dec);
        exp_q.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 4'b0100));
        exp_q.push_back(e_idle);
        drain("mov_imm7", -1, -1);

        // MOV R1,#-2
        launch(16'hD1FE, 1'b0);
        check("movm2_sximm8", {16'd0, sximm8}, 32'h0000_FFFE);
        check("movm2_sximm5", {16'd0, sximm5}, 32'h0000_FFFE);
        exp_q.push_back(e_dec);
        exp_q.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 4'b0100));
        exp_q.push_back(e_idle);
        drain("mov_imm_m2", -1, -1);

        // ADD R2,R2,R0,LSL#1
        launch(16'hA248, 1'b0);
        check("add_aluop", {30'd0, ALUop}, 32'd0);
        check("add_shift", {30'd0, shift}, 32'd1);
        exp_q.push_back(e_dec);
        exp_q.push_back(mk(0, 2, 0, 0, 1, 0, 0, 0, 0, 4'b0000));
        exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 4'b0000));
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 4'b0000));
        exp_q.push_back(mk(0, 0, 2, 1, 0, 0, 0, 0, 0, 4'b0001));
        exp_q.push_back(e_idle);
        drain("add", -1, -1);

        // CMP R1,R0
        launch(16'hA900, 1'b0);
        check("cmp_aluop", {30'd0, ALUop}, 32'd1);
        exp_q.push_back(e_dec);
        exp_q.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, 0, 4'b0000));
        exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 4'b0000));
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 4'b0000));
        exp_q.push_back(e_idle);
        drain("cmp", -1, -1);

        // MOV R3,R5,LSR#1 (register move uses asel=1, ALUop forced 00)
        launch(16'hC075, 1'b0);
        check("movr_aluop", {30'd0, ALUop}, 32'd0);
        check("movr_shift", {30'd0, shift}, 32'd2);
        exp_q.push_back(e_dec);
        exp_q.push_back(mk(0, 5, 0, 0, 0, 1, 0, 0, 0, 4'b0000));
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 4'b0000));
        exp_q.push_back(mk(0, 0, 3, 1, 0, 0, 0, 0, 0, 4'b0001));
        exp_q.push_back(e_idle);
        drain("mov_reg", -1, -1);

        // AND R4,R3,R1
        launch(16'hB381, 1'b0);
        check("and_aluop", {30'd0, ALUop}, 32'd2);
        exp_q.push_back(e_dec);
        exp_q.push_back(mk(0, 3, 0, 0, 1, 0, 0, 0, 0, 4'b0000));
        exp_q.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0, 0, 4'b0000));
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 4'b0000));
        exp_q.push_back(mk(0, 0, 4, 1, 0, 0, 0, 0, 0, 4'b0001));
        exp_q.push_back(e_idle);
        drain("and", -1, -1);

        // Undefined encoding: one edge back to WAIT, no enables
        launch(16'hE000, 1'b0);
        exp_q.push_back(e_dec);
        exp_q.push_back(e_idle);
        drain("undef", -1, -1);

        // Simultaneous load and start: DECODE sees the new word (MOV R0,#7)
        launch(16'hD007, 1'b1);
        exp_q.push_back(e_dec);
        exp_q.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 4'b0100));
        exp_q.push_back(e_idle);
        drain("load_and_start", -1, -1);

        // Load pulsed during GET_B must not alter the IR
        launch(16'hA248, 1'b0);
        exp_q.push_back(e_dec);
        exp_q.push_back(mk(0, 2, 0, 0, 1, 0, 0, 0, 0, 4'b0000));
        exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 4'b0000));
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 4'b0000));
        exp_q.push_back(mk(0, 0, 2, 1, 0, 0, 0, 0, 0, 4'b0001));
        exp_q.push_back(e_idle);
        drain("load_in_getb", 2, -1);
        check("ir_kept_sximm8", {16'd0, sximm8}, 32'h0000_0048);

        // Reset asserted in ALU aborts the instruction: next cycle idle
        launch(16'hA248, 1'b0);
        exp_q.push_back(e_dec);
        exp_q.push_back(mk(0, 2, 0, 0, 1, 0, 0, 0, 0, 4'b0000));
        exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 4'b0000));
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 4'b0000));
        exp_q.push_back(e_idle);
        drain("reset_in_alu", -1, 3);
        check("reset_in_alu_ir", {16'd0, sximm8}, 32'h0000_0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
